// File: rtl/clock_time_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by rising edges of a 1 Hz strobe,
// with validated parallel load and 12/24-hour formats.
module clock_time_counter #(
  parameter int HOURS = 24  // 12 or 24; any value other than 12 behaves as 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       puls_1,
  input  logic       run_en,
  input  logic       load,
  input  logic [7:0] load_h,
  input  logic [7:0] load_m,
  input  logic [7:0] load_s,
  input  logic       load_pm,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic       sec_pulse,
  output logic       hour_chime,
  output logic       load_err
);

  localparam bit         FMT12      = (HOURS == 12);
  localparam logic [7:0] HOUR_RESET = FMT12 ? 8'h12 : 8'h00;

  logic puls_d;
  logic tick;
  logic load_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] next_hour(input logic [7:0] h);
    if (FMT12) begin
      if (h == 8'h12) return 8'h01;
      else            return bcd_inc(h);
    end else begin
      if (h == 8'h23) return 8'h00;
      else            return bcd_inc(h);
    end
  endfunction

  assign tick = puls_1 & ~puls_d;

  // Once every nibble is a valid digit, BCD values order the same as binary.
  always_comb begin
    load_ok = is_bcd(load_h) && is_bcd(load_m) && is_bcd(load_s) &&
              (load_m <= 8'h59) && (load_s <= 8'h59);
    if (FMT12) load_ok = load_ok && (load_h >= 8'h01) && (load_h <= 8'h12);
    else       load_ok = load_ok && (load_h <= 8'h23);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      puls_d     <= 1'b1;
      hour_bcd   <= HOUR_RESET;
      min_bcd    <= 8'h00;
      sec_bcd    <= 8'h00;
      pm         <= 1'b0;
      sec_pulse  <= 1'b0;
      hour_chime <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      puls_d     <= puls_1;
      sec_pulse  <= 1'b0;
      hour_chime <= 1'b0;
      load_err   <= 1'b0;
      if (load) begin
        // A load always consumes the cycle; a coincident tick is dropped.
        if (load_ok) begin
          hour_bcd <= load_h;
          min_bcd  <= load_m;
          sec_bcd  <= load_s;
          pm       <= FMT12 ? load_pm : 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick && run_en) begin
        sec_pulse <= 1'b1;
        if (sec_bcd == 8'h59) begin
          sec_bcd <= 8'h00;
          if (min_bcd == 8'h59) begin
            min_bcd    <= 8'h00;
            hour_chime <= 1'b1;
            hour_bcd   <= next_hour(hour_bcd);
            if (FMT12 && hour_bcd == 8'h11) pm <= ~pm;
          end else begin
            min_bcd <= bcd_inc(min_bcd);
          end
        end else begin
          sec_bcd <= bcd_inc(sec_bcd);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench: directed vector table plus randomized stimulus against a
// seconds-of-day reference model, covering a 24-hour and a 12-hour instance.
module tb_clock_time_counter;

  logic       clk = 1'b0;
  logic       rst, puls_1, run_en, load, load_pm;
  logic [7:0] load_h, load_m, load_s;

  logic [7:0] h_a, m_a, s_a, h_b, m_b, s_b;
  logic       pm_a, sp_a, ch_a, err_a, pm_b, sp_b, ch_b, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  clock_time_counter #(.HOURS(24)) dut24 (
    .clk(clk), .rst(rst), .puls_1(puls_1), .run_en(run_en), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s), .load_pm(load_pm),
    .hour_bcd(h_a), .min_bcd(m_a), .sec_bcd(s_a), .pm(pm_a),
    .sec_pulse(sp_a), .hour_chime(ch_a), .load_err(err_a));

  clock_time_counter #(.HOURS(12)) dut12 (
    .clk(clk), .rst(rst), .puls_1(puls_1), .run_en(run_en), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s), .load_pm(load_pm),
    .hour_bcd(h_b), .min_bcd(m_b), .sec_bcd(s_b), .pm(pm_b),
    .sec_pulse(sp_b), .hour_chime(ch_b), .load_err(err_b));

  // Reference model: time kept as seconds since midnight (24-hour clock).
  bit m_pd;
  int t24, t12;
  bit m_sp, m_ch24, m_ch12, m_e24, m_e12;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic bit dec(input logic [7:0] b, output int v);
    v = int'(b[7:4]) * 10 + int'(b[3:0]);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [27:0] exp24();
    return {to_bcd(t24 / 3600), to_bcd((t24 / 60) % 60), to_bcd(t24 % 60),
            1'b0, m_sp, m_ch24, m_e24};
  endfunction

  function automatic logic [27:0] exp12();
    int h;
    h = (t12 / 3600) % 12;
    if (h == 0) h = 12;
    return {to_bcd(h), to_bcd((t12 / 60) % 60), to_bcd(t12 % 60),
            1'(t12 >= 43200), m_sp, m_ch12, m_e12};
  endfunction

  task automatic model_step(input logic r, p, run, ld, input logic [7:0] h, m, s,
                            input logic lpm);
    int hv, mv, sv;
    bit ok;
    m_sp = 0; m_ch24 = 0; m_ch12 = 0; m_e24 = 0; m_e12 = 0;
    if (r) begin
      t24 = 0; t12 = 0; m_pd = 1;
    end else begin
      bit tick;
      tick = p && !m_pd;
      m_pd = p;
      if (ld) begin
        ok = dec(h, hv) & dec(m, mv) & dec(s, sv) && mv <= 59 && sv <= 59;
        if (ok && hv <= 23) t24 = hv * 3600 + mv * 60 + sv;
        else                m_e24 = 1;
        if (ok && hv >= 1 && hv <= 12) t12 = ((hv % 12) + (lpm ? 12 : 0)) * 3600 + mv * 60 + sv;
        else                           m_e12 = 1;
      end else if (tick && run) begin
        t24 = (t24 + 1) % 86400;
        t12 = (t12 + 1) % 86400;
        m_sp = 1;
        m_ch24 = (t24 % 3600 == 0);
        m_ch12 = (t12 % 3600 == 0);
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic drive(input logic r, p, run, ld, input logic [7:0] h, m, s,
                       input logic lpm);
    rst = r; puls_1 = p; run_en = run; load = ld;
    load_h = h; load_m = m; load_s = s; load_pm = lpm;
    model_step(r, p, run, ld, h, m, s, lpm);
    @(posedge clk);
    #1;
    check("model24", {h_a, m_a, s_a, pm_a, sp_a, ch_a, err_a}, exp24());
    check("model12", {h_b, m_b, s_b, pm_b, sp_b, ch_b, err_b}, exp12());
  endtask

  typedef struct {
    logic       rst, p, run, ld;
    logic [7:0] h, m, s;
    logic [7:0] eh, em, es;
    logic       esp, ech, eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, p, run, ld, input logic [7:0] h, m, s,
                     input logic [7:0] eh, em, es, input logic esp, ech, eerr);
    vec_t v;
    v.rst = r; v.p = p; v.run = run; v.ld = ld; v.h = h; v.m = m; v.s = s;
    v.eh = eh; v.em = em; v.es = es; v.esp = esp; v.ech = ech; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  initial begin
    // Reset, then three ticks (the first high after reset is not a tick).
    add(1, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 0, 0, 0);
    // Day wrap with chime on the second tick only.
    add(0, 0, 1, 1, 8'h23, 8'h59, 8'h58, 8'h23, 8'h59, 8'h58, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h23, 8'h59, 8'h59, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h23, 8'h59, 8'h59, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    // BCD carry from 09 to 10 hours.
    add(0, 0, 1, 1, 8'h09, 8'h59, 8'h59, 8'h09, 8'h59, 8'h59, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0);
    // Rejected loads.
    add(0, 0, 1, 1, 8'h24, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 0, 0, 1);
    add(0, 0, 1, 1, 8'h12, 8'h5A, 8'h00, 8'h10, 8'h00, 8'h00, 0, 0, 1);
    add(0, 0, 1, 1, 8'h12, 8'h60, 8'h00, 8'h10, 8'h00, 8'h00, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0);
    // Load beats a coincident tick.
    add(0, 1, 1, 1, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h01, 8'h02, 8'h03, 0, 0, 0);
    // Five ticks dropped while stopped.
    for (int i = 0; i < 5; i++) begin
      add(0, 1, 0, 0, 0, 0, 0, 8'h01, 8'h02, 8'h03, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h01, 8'h02, 8'h03, 0, 0, 0);
    end
    add(0, 1, 1, 0, 0, 0, 0, 8'h01, 8'h02, 8'h04, 1, 0, 0);
    // Reset mid-count with puls_1 high: no tick on exit.
    add(1, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].p, tbl[i].run, tbl[i].ld, tbl[i].h, tbl[i].m, tbl[i].s, 1'b0);
      check($sformatf("row%0d", i), {h_a, m_a, s_a, sp_a, ch_a, err_a},
            {tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].esp, tbl[i].ech, tbl[i].eerr});
    end

    // 12-hour wraps: 11:59:59am -> 12:00:00pm, 12:59:59pm -> 01:00:00pm.
    drive(0, 0, 1, 1, 8'h11, 8'h59, 8'h59, 1'b0);
    drive(0, 1, 1, 0, 0, 0, 0, 1'b0);
    check("h12_noon", {h_b, m_b, s_b, pm_b, ch_b}, {8'h12, 8'h00, 8'h00, 1'b1, 1'b1});
    drive(0, 0, 1, 1, 8'h12, 8'h59, 8'h59, 1'b1);
    drive(0, 1, 1, 0, 0, 0, 0, 1'b0);
    check("h12_one", {h_b, m_b, s_b, pm_b}, {8'h01, 8'h00, 8'h00, 1'b1});
    drive(0, 0, 1, 1, 8'h11, 8'h59, 8'h59, 1'b1);
    drive(0, 1, 1, 0, 0, 0, 0, 1'b0);
    check("h12_midnight", {h_b, pm_b}, {8'h12, 1'b0});
    check("h24_pm_zero", {31'd0, pm_a}, 32'd0);

    // Randomized phase against the model.
    for (int i = 0; i < 4000; i++) begin
      logic r, p, run, ld, lpm;
      logic [7:0] h, m, s;
      r   = ($urandom_range(0, 599) == 0);
      p   = ($urandom_range(0, 2) == 0) ? ~puls_1 : puls_1;
      run = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 24) == 0);
      lpm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        h = to_bcd($urandom_range(0, 23));
        m = ($urandom_range(0, 1) == 1) ? 8'h59 : to_bcd($urandom_range(0, 59));
        s = to_bcd($urandom_range(50, 59));
      end else begin
        h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      end
      drive(r, p, run, ld, h, m, s, lpm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
